// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache.
//   - default geometry (lines, words per line, address width)
//   - derived field widths for the default geometry
//   - controller state encoding
//   - helpers that slice a fetch address into index / tag / word-select
// The helpers take explicit field widths so a non-default geometry can
// reuse them unchanged.
// ---------------------------------------------------------------------------
package icache_pkg;

  localparam int ENTRIES_DEF    = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int ADDR_W_DEF     = 32;

  localparam int OFF_W = $clog2(LINE_WORDS_DEF) + 2;
  localparam int IDX_W = $clog2(ENTRIES_DEF);
  localparam int TAG_W = ADDR_W_DEF - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Extract 'width' bits of 'pc' starting at bit 'lsb'; a zero width yields 0.
  function automatic logic [63:0] pc_field(input logic [63:0] pc, input int lsb, input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (pc >> lsb) & mask;
  endfunction

  // Line index sits directly above the byte offset within the line.
  function automatic logic [63:0] get_index(input logic [63:0] pc, input int off_w, input int idx_w);
    return pc_field(pc, off_w, idx_w);
  endfunction

  // Tag is everything above the index.
  function automatic logic [63:0] get_tag(input logic [63:0] pc, input int off_w, input int idx_w,
                                          input int tag_w);
    return pc_field(pc, off_w + idx_w, tag_w);
  endfunction

  // Word select ignores the two byte-within-word bits.
  function automatic logic [63:0] get_word(input logic [63:0] pc, input int off_w);
    return pc_field(pc, 2, off_w - 2);
  endfunction

endpackage

// File: rtl/icache_if.sv
// ---------------------------------------------------------------------------
// icache_if
// Bundles the fetch-unit side and the memory-controller side of the cache.
//   ifu_req / ifu_pc / flush        : fetch request, address, mispredict flush
//   ifu_valid / ifu_inst            : one-cycle instruction return
//   mem_req / mem_addr              : word request towards memctrl
//   mem_received / mem_done / mem_data : memctrl accept pulse, completion
//                                     pulse and returned word
// Modports:
//   slave  - the cache controller
//   master - the environment (fetch unit + memory controller)
// ---------------------------------------------------------------------------
interface icache_if
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_pc;
  logic              ifu_valid;
  logic [31:0]       ifu_inst;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_received;
  logic              mem_done;
  logic [31:0]       mem_data;

  modport slave (
    input  ifu_req, ifu_pc, flush, mem_received, mem_done, mem_data,
    output ifu_valid, ifu_inst, mem_req, mem_addr
  );

  modport master (
    output ifu_req, ifu_pc, flush, mem_received, mem_done, mem_data,
    input  ifu_valid, ifu_inst, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
// Storage for the direct-mapped cache: one valid bit, one tag and
// LINE_WORDS data words per line.
// Ports:
//   clk_in, rst_n_in     : clock, async active-low reset (clears valid bits)
//   rd_idx, rd_word      : combinational read address
//   rd_valid, rd_tag, rd_data : line status and selected word
//   wr_en, wr_idx, wr_word, wr_data : one-word synchronous write
//   set_en, set_tag      : marks line wr_idx valid with set_tag
// ---------------------------------------------------------------------------
module icache_array
  import icache_pkg::*;
#(
  parameter int ENTRIES    = ENTRIES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TAG_BITS   = TAG_W,
  parameter int INDEX_W    = $clog2(ENTRIES),
  parameter int CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [INDEX_W-1:0]  rd_idx,
  input  logic [CNT_W-1:0]    rd_word,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_idx,
  input  logic [CNT_W-1:0]    wr_word,
  input  logic [31:0]         wr_data,
  input  logic                set_en,
  input  logic [TAG_BITS-1:0] set_tag
);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q  [ENTRIES];
  logic [31:0]         data_q [ENTRIES][LINE_WORDS];

  // Lookup is purely combinational so a hit can be answered in one cycle.
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

  // Valid bits are the only state that must come up clean after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tags and data need no reset; they are meaningless until valid is set.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      data_q[wr_idx][wr_word] <= wr_data;
    end
    if (set_en) begin
      tag_q[wr_idx] <= set_tag;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped instruction cache controller. Hits return one cycle after
// the request; misses fetch the whole line word by word (word 0 first)
// through the memctrl request/received/done handshake and then return the
// requested word. A flush during a fill lets the fill finish (memctrl cannot
// abort) but suppresses the response.
// Ports:
//   clk_in   : clock
//   rst_n_in : asynchronous active-low reset
//   rdy_in   : global ready; low freezes every register
//   bus      : icache_if.slave (fetch side + memctrl side)
// ---------------------------------------------------------------------------
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ENTRIES    = ENTRIES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic    clk_in,
  input  logic    rst_n_in,
  input  logic    rdy_in,
  icache_if.slave bus
);

  localparam int LINE_OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int INDEX_W    = $clog2(ENTRIES);
  localparam int TAG_BITS   = ADDR_W - LINE_OFF_W - INDEX_W;
  localparam int CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << LINE_OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(LINE_WORDS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    sel;
  logic                drop;

  logic [INDEX_W-1:0]  pc_idx;
  logic [TAG_BITS-1:0] pc_tag;
  logic [CNT_W-1:0]    pc_sel;
  logic [INDEX_W-1:0]  base_idx;
  logic [TAG_BITS-1:0] base_tag;

  logic [INDEX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]    rd_word;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_data;
  logic                hit;
  logic                wr_en;
  logic                set_en;

  // Address fields for the incoming fetch and for the line being filled.
  assign pc_idx   = INDEX_W'(get_index(64'(bus.ifu_pc), LINE_OFF_W, INDEX_W));
  assign pc_tag   = TAG_BITS'(get_tag(64'(bus.ifu_pc), LINE_OFF_W, INDEX_W, TAG_BITS));
  assign pc_sel   = CNT_W'(get_word(64'(bus.ifu_pc), LINE_OFF_W));
  assign base_idx = INDEX_W'(get_index(64'(base), LINE_OFF_W, INDEX_W));
  assign base_tag = TAG_BITS'(get_tag(64'(base), LINE_OFF_W, INDEX_W, TAG_BITS));

  // In IDLE the array is looked up with the live pc; in RESP it returns the
  // requested word of the line that has just been installed.
  assign rd_idx  = (state == IDLE) ? pc_idx : base_idx;
  assign rd_word = (state == IDLE) ? pc_sel : sel;
  assign hit     = rd_valid && (rd_tag == pc_tag);

  // Each completed word is stored as it arrives; the tag and valid bit are
  // only set alongside the last word so a partial line never looks valid.
  assign wr_en  = rdy_in && (state == WAIT) && bus.mem_done;
  assign set_en = wr_en && (cnt == LAST_WORD);

  icache_array #(
    .ENTRIES    (ENTRIES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS),
    .INDEX_W    (INDEX_W),
    .CNT_W      (CNT_W)
  ) u_array (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rd_idx   (rd_idx),
    .rd_word  (rd_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (base_idx),
    .wr_word  (cnt),
    .wr_data  (bus.mem_data),
    .set_en   (set_en),
    .set_tag  (base_tag)
  );

  // Controller FSM with registered outputs. mem_req/mem_addr are loaded on
  // the edge that enters REQ, so mem_req is high exactly while in REQ and
  // the word address is the line base plus the word counter. Flush in IDLE
  // blocks the hit response; anywhere else it sets the drop flag, which
  // RESP consumes (a flush arriving in RESP itself also suppresses it).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      base          <= '0;
      cnt           <= '0;
      sel           <= '0;
      drop          <= 1'b0;
      bus.ifu_valid <= 1'b0;
      bus.ifu_inst  <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
    end else if (rdy_in) begin
      bus.ifu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ifu_req && !bus.flush) begin
            if (hit) begin
              bus.ifu_inst  <= rd_data;
              bus.ifu_valid <= 1'b1;
            end else begin
              base         <= bus.ifu_pc & ~OFF_MASK;
              sel          <= pc_sel;
              cnt          <= '0;
              drop         <= 1'b0;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= bus.ifu_pc & ~OFF_MASK;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.flush) begin
            drop <= 1'b1;
          end
          if (bus.mem_received) begin
            bus.mem_req <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.flush) begin
            drop <= 1'b1;
          end
          if (bus.mem_done) begin
            if (cnt == LAST_WORD) begin
              state <= RESP;
            end else begin
              cnt          <= cnt + CNT_W'(1);
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= base | (ADDR_W'(cnt + CNT_W'(1)) << 2);
              state        <= REQ;
            end
          end
        end
        RESP: begin
          if (!drop && !bus.flush) begin
            bus.ifu_inst  <= rd_data;
            bus.ifu_valid <= 1'b1;
          end
          drop  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache and controller between the instruction-fetch unit and the memory controller's icache port.
- Serves fetch hits from local storage in 1 cycle.
- On a miss, fetches the whole line from the memory controller as a series of 4-byte word requests using the request/received/task-done handshake, then returns the requested word.
- Handles flush (mispredict) and the global ready/halt signals.

Parameters:
- ENTRIES, 16, number of lines; power of two, >= 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, >= 1.
- ADDR_W, 32, address width.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global ready; low freezes all state
- ifu_req  input  1  fetch request, held until ifu_valid
- ifu_pc  input  ADDR_W  fetch address; bits [1:0] ignored
- ifu_valid  output  1  one-cycle pulse, instruction valid
- ifu_inst  output  32  fetched instruction
- flush  input  1  discard the outstanding fetch
- mem_req  output  1  to memctrl icache_in
- mem_addr  output  ADDR_W  to memctrl icache_address_in
- mem_received  input  1  memctrl icache_received pulse
- mem_done  input  1  memctrl icache_task_out pulse
- mem_data  input  32  memctrl value_load, valid with mem_done

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS)+2 bits of offset.
  - index = pc[OFF+log2(ENTRIES)-1:OFF].
  - tag = remaining upper bits.
  - word select = pc[OFF-1:2].
- Reset (async, rst_n_in=0): every line invalid; state IDLE; ifu_valid=0, ifu_inst=0, mem_req=0, mem_addr=0; fill counter 0; drop flag 0.
- rdy_in=0: no register changes, outputs hold.
- IDLE:
  - If ifu_req && !flush && hit: ifu_inst <= stored word, ifu_valid=1 next cycle, stay IDLE. Hit latency is exactly 1 cycle.
  - If ifu_req && !flush && miss: latch line base (pc with offset bits cleared), clear counter, go REQ.
- REQ:
  - mem_req=1, mem_addr = base + 4*counter.
  - On the edge where mem_received=1 is sampled, drop mem_req and go WAIT.
  - mem_req is never high outside REQ.
- WAIT:
  - On mem_done: write mem_data into data[index][counter].
  - If counter == LINE_WORDS-1: set valid and tag, go RESP. Otherwise counter+1, go REQ.
  - mem_done in any state other than WAIT is ignored.
- RESP:
  - If drop flag is 0: ifu_inst = requested word, ifu_valid=1 for 1 cycle.
  - Clear drop flag, go IDLE.
  - Miss latency is set by memctrl; words are always fetched in order, word 0 first.
- flush:
  - In IDLE it suppresses any hit response in that cycle.
  - In REQ/WAIT/RESP it sets the drop flag.
  - The fill still runs to completion, because memctrl cannot abort a transaction. The line is installed, but no ifu_valid is produced for it.
  - flush has priority over a same-cycle hit.
- A new ifu_req is accepted only in IDLE. Requests arriving during a fill wait, since ifu_req is held.
- The line is written to storage only after its last word. A partially filled line is never marked valid.
- Counter width is log2(LINE_WORDS), minimum 1 bit. base+4*counter never wraps beyond the line.
- Reset mid-fill returns to IDLE immediately and drops mem_req. memctrl is reset by the same event.

Decomposition:
- Package icache_pkg holds:
  - state enum IDLE/REQ/WAIT/RESP;
  - localparams OFF_W, IDX_W, TAG_W derived from the parameters;
  - helper functions for the index/tag/word-select fields.
- One sub-module, icache_array: valid bits, tags and data words.
  - Read is combinational by index.
  - Write is synchronous: one word per cycle, plus a tag/valid set strobe.
  - Valid bits clear on async reset.

Test Plan:
- Reset: drive rst_n_in=0 mid-sim, then release, then request pc 0x10 -> mem_req rises within 1 cycle of release+request, and all lines are treated as invalid.
- Cold miss: pc=0x0000_0010 with defaults -> mem_addr sequence 0x10, 0x14, 0x18, 0x1C, one request per received/done pair. ifu_valid 1 cycle after the 4th mem_done, with ifu_inst = the word returned for 0x10.
- Hit after fill: pc=0x0000_0018 -> ifu_valid exactly 1 cycle later, no mem_req, data = the 3rd word filled.
- Conflict miss: pc=0x0000_0110 (index 1, different tag) -> full refill 0x110..0x11C. A later pc=0x10 misses again.
- Flush mid-fill: assert flush during the 2nd word's WAIT -> all 4 words still requested, no ifu_valid. A following pc=0x14 hits in 1 cycle.
- rdy_in low for 5 cycles during REQ -> mem_req and mem_addr hold steady, and mem_received pulses during the stall have no effect; normal completion after rdy_in returns.
